// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_kbd_rx
//  Description : PS/2 keyboard receiver. Synchronises the pad clock/data,
//                deframes 11-bit odd-parity frames and buffers good bytes in a
//                first-word fall-through FIFO with sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 2400
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_dat_i,
    input  logic                          en_i,
    input  logic                          rd_i,
    input  logic                          clr_i,
    output logic [7:0]                    dat_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   cnt_o,
    output logic                          perr_o,
    output logic                          ovf_o,
    output logic                          irq_o
);

    localparam int                c_AW   = $clog2(FIFO_DEPTH);
    localparam int                c_TW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_TW-1:0]   c_TMO  = c_TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchroniser and edge-history flops; idle-high so reset never looks like a fall
    logic r_clk_s1, r_clk_s2, r_clk_d;
    logic r_dat_s1, r_dat_s2;
    logic w_fall;

    // Deframer state
    state_t          r_state, w_state_nxt;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic            r_parity;
    logic [c_TW-1:0] r_tmo;
    logic            w_tmo_hit;
    logic            w_push;
    logic            w_frame_err;
    logic            w_tmo_err;

    // FIFO
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]   r_cnt;
    logic            w_full, w_pop, w_wr, w_ovf;

    logic            r_perr, r_ovf;

    // Two-flop synchronisers plus one delay stage for fall detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_d  <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_clk_d  <= r_clk_s2;
            r_dat_s1 <= ps2_dat_i;
            r_dat_s2 <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_d & ~r_clk_s2;
    assign w_tmo_hit = (r_state != IDLE) && (r_tmo == c_TMO);

    // Next-state and frame-event decode; disable and timeout override bit handling
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        w_tmo_err   = 1'b0;
        if (!en_i) begin
            w_state_nxt = IDLE;
        end else if (w_tmo_hit) begin
            w_state_nxt = IDLE;
            w_tmo_err   = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    if (!r_dat_s2) w_state_nxt = DATA;
                DATA:    if (r_bitcnt == 3'd7) w_state_nxt = PARITY;
                PARITY:  w_state_nxt = STOP;
                STOP: begin
                    w_state_nxt = IDLE;
                    // Odd parity across data+parity, and a high stop bit
                    if ((^{r_shift, r_parity}) && r_dat_s2) w_push = 1'b1;
                    else                                    w_frame_err = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register and shift/parity capture on PS/2 clock falls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_bitcnt <= 3'd0;
            r_shift  <= 8'h00;
            r_parity <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!en_i || w_tmo_hit) begin
                r_bitcnt <= 3'd0;
                r_shift  <= 8'h00;
            end else if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        r_bitcnt <= 3'd0;
                        r_shift  <= 8'h00;
                    end
                    DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    PARITY:  r_parity <= r_dat_s2;
                    default: ;
                endcase
            end
        end
    end

    // Inter-edge watchdog: restarts on each fall, idles at zero outside a frame
    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i || w_fall || (r_state == IDLE)) begin
            r_tmo <= '0;
        end else if (r_tmo != c_TMO) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_full = (r_cnt == c_FULL);
    assign w_pop  = rd_i && (r_cnt != '0);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_ovf  = w_push && w_full && !w_pop;

    // FIFO storage; contents are masked at the output while empty
    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_frame_err || w_tmo_err) r_perr <= 1'b1;
            else if (clr_i)               r_perr <= 1'b0;
            if (w_ovf)                    r_ovf  <= 1'b1;
            else if (clr_i)               r_ovf  <= 1'b0;
        end
    end

    assign valid_o = (r_cnt != '0);
    assign dat_o   = valid_o ? r_mem[r_rd_ptr] : 8'h00;
    assign cnt_o   = r_cnt;
    assign perr_o  = r_perr;
    assign ovf_o   = r_ovf;
    assign irq_o   = valid_o & en_i;

endmodule
`default_nettype wire

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 2400, clk_i cycles allowed between PS/2 clock falls inside a frame (100 us at 24 MHz).
REQ-003 SHALL have port clk_i  input  1  system clock; single clock domain for all logic.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk_i  input  1  PS/2 clock from the pad, asynchronous to clk_i.
REQ-006 SHALL have port ps2_dat_i  input  1  PS/2 data from the pad, asynchronous to clk_i.
REQ-007 SHALL have port en_i  input  1  receiver enable.
REQ-008 SHALL have port rd_i  input  1  pop FIFO head.
REQ-009 SHALL have port clr_i  input  1  clear sticky error flags.
REQ-010 SHALL have port dat_o  output  8  FIFO head byte.
REQ-011 SHALL have port valid_o  output  1  FIFO not empty.
REQ-012 SHALL have port cnt_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have port perr_o  output  1  sticky frame/parity/timeout error.
REQ-014 SHALL have port ovf_o  output  1  sticky overflow.
REQ-015 SHALL have port irq_o  output  1  interrupt, equal to valid_o & en_i.

Function
REQ-016 SHALL pass ps2_clk_i and ps2_dat_i each through a 2-flop synchronizer; a fall is a synchronized clock of 0 with a previous-cycle value of 1, detected in one clk_i cycle (a fall edge).
REQ-017 SHALL sample the synchronized data only on fall edges.
REQ-018 SHALL use FSM states IDLE, DATA, PARITY, STOP.
REQ-019 IDLE SHALL move to DATA on a fall edge with data 0 (start bit), and SHALL ignore a fall edge with data 1.
REQ-020 DATA SHALL shift in 8 bits LSB first on 8 fall edges via a 3-bit counter, then move to PARITY.
REQ-021 PARITY SHALL capture the parity bit on one fall edge, then move to STOP.
REQ-022 STOP SHALL evaluate the frame on one fall edge and return to IDLE.
REQ-023 A frame SHALL be good when the 8 data bits plus the parity bit contain an odd number of ones and stop=1.
REQ-024 A good frame SHALL push the byte in the same cycle as the stop fall edge; valid_o and dat_o update in the next cycle.
REQ-025 A bad frame SHALL drop the byte and set perr_o.
REQ-026 A timeout counter SHALL clear on every fall edge and count while the FSM is not IDLE.
REQ-027 On reaching TIMEOUT_CYC, the timeout SHALL return the FSM to IDLE, set perr_o and discard the partial byte.
REQ-028 en_i=0 SHALL force the FSM to IDLE, abort any partial frame without an error, and leave FIFO contents readable.
REQ-029 The FIFO SHALL be first-word fall-through: dat_o = head while valid_o=1, and 8'h00 when empty.
REQ-030 rd_i with valid_o=1 SHALL pop in one cycle; rd_i while empty SHALL be ignored with no state change.
REQ-031 A push while full without a same-cycle pop SHALL drop the byte and set ovf_o.
REQ-032 A push and pop in the same cycle SHALL both take effect, including when full; cnt_o is unchanged and ovf_o is not set.
REQ-033 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 cnt_o SHALL range 0..FIFO_DEPTH.
REQ-035 clr_i SHALL clear perr_o and ovf_o next cycle; a same-cycle set event SHALL win over clr_i.

Reset
REQ-036 While rst_i=1 at a clk_i edge, the block SHALL set FSM=IDLE, FIFO pointers=0, cnt_o=0, valid_o=0, dat_o=8'h00, perr_o=0, ovf_o=0, irq_o=0, timeout=0, shift register=0.
REQ-037 Synchronizer flops SHALL reset to 1 (PS/2 idle high), so no fall edge is seen after reset.
REQ-038 Reset mid-frame SHALL discard the partial frame with no push and no error.

Verification
REQ-039 Bench SHALL send frame 0x41 with parity 1 and stop 1 -> one cycle after the stop fall edge valid_o=1, dat_o=0x41, cnt_o=1, irq_o=1; rd_i pulse -> cnt_o=0, valid_o=0.
REQ-040 Bench SHALL send 0x41 with parity 0 -> cnt_o stays 0, perr_o=1; clr_i pulse -> perr_o=0.
REQ-041 Bench SHALL send 9 good frames 0x41..0x49 with no reads (FIFO_DEPTH=8) -> cnt_o=8, ovf_o=1, pops yield 0x41..0x48 in order, 0x49 lost.
REQ-042 Bench SHALL send start plus 4 data bits, then idle 2500 cycles -> perr_o=1, FSM IDLE; a following good 0x5A frame is received correctly.
REQ-043 Bench SHALL fill the FIFO to 8, then assert rd_i in the stop-edge push cycle of 0x4A -> cnt_o stays 8, ovf_o=0, last entry 0x4A.
REQ-044 Bench SHALL assert rst_i after the 5th data bit of a frame -> all outputs at reset values; the next good frame 0x1C is received with perr_o=0.
